// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU operation decoder with an iterative RV32M/RV64M multiply/divide engine.
// Define MULDIV_FAST_SPECIAL_EN to finish zero-multiply, divide-by-zero and overflow ops in one cycle.
module alu_ctrl_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            op_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [3:0]      Operation,
    output logic            is_muldiv,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic special(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return f3[2] ? (b == '0 || (!f3[0] && a == MIN && b == '1)) : (a == '0 || b == '0);
    endfunction

    function automatic logic [XLEN-1:0] special_val(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return f3[2] ? (b == '0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a)) : '0;
    endfunction

    state_t            state, state_nx;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   hi, lo, m, a_q, b_q;
    logic [2:0]        f3_q;
    logic              neg_q, sa_q;
    logic              start, signed_a, signed_b, sa, sb, ge;
    logic [XLEN-1:0]   a_mag, b_mag, nx_hi, nx_lo, quo, rem_v, fin;
    logic [XLEN:0]     sum, tmp, diff;
    logic [2*XLEN-1:0] prod;

    assign is_muldiv    = op_valid && ALUOp == 2'b10 && Funct7 == 7'b0000001;
    assign stall        = is_muldiv && state != DONE;
    assign busy         = state == BUSY;
    assign result_valid = state == DONE;
    assign start        = state == IDLE && is_muldiv && !flush;

    always_comb begin
        Operation = is_muldiv ? 4'b1111 :
                    Funct3 == 3'b000 ? ((ALUOp == 2'b10 && Funct7 == 7'b0100000) ? 4'b0110 : 4'b0010) :
                    Funct3 == 3'b010 ? 4'b0111 :
                    Funct3 == 3'b100 ? 4'b1100 :
                    Funct3 == 3'b110 ? 4'b0001 :
                    Funct3 == 3'b111 ? 4'b0000 : 4'b0010;
    end

    // Engines run on magnitudes; signs are reapplied when the result is formed.
    always_comb begin
        signed_a = Funct3[2] ? !Funct3[0] : Funct3[1:0] != 2'b11;
        signed_b = Funct3[2] ? !Funct3[0] : !Funct3[1];
        sa       = signed_a && operand_a[XLEN-1];
        sb       = signed_b && operand_b[XLEN-1];
        a_mag    = sa ? -operand_a : operand_a;
        b_mag    = sb ? -operand_b : operand_b;
    end

    // Mul: {hi,lo} shift-add with multiplier in lo. Div: restoring, remainder in hi, quotient shifts into lo.
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        tmp   = {hi, lo[XLEN-1]};
        diff  = tmp - {1'b0, m};
        ge    = tmp >= {1'b0, m};
        nx_hi = f3_q[2] ? (ge ? diff[XLEN-1:0] : tmp[XLEN-1:0]) : sum[XLEN:1];
        nx_lo = f3_q[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
        prod  = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};
        quo   = neg_q ? -nx_lo : nx_lo;
        rem_v = sa_q ? -nx_hi : nx_hi;
        fin   = special(f3_q, a_q, b_q) ? special_val(f3_q, a_q, b_q) :
                f3_q[2] ? (f3_q[1] ? rem_v : quo) :
                f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = IDLE;
        else
            unique case (state)
                IDLE:    state_nx = start ? ((FAST && special(Funct3, operand_a, operand_b)) ? DONE : BUSY) : IDLE;
                BUSY:    state_nx = count == CNT_W'(XLEN-1) ? DONE : BUSY;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            sa_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                a_q   <= operand_a;
                b_q   <= operand_b;
                f3_q  <= Funct3;
                neg_q <= sa ^ sb;
                sa_q  <= sa;
                count <= '0;
                hi    <= '0;
                lo    <= Funct3[2] ? a_mag : b_mag;
                m     <= Funct3[2] ? b_mag : a_mag;
                if (state_nx == DONE)
                    result <= special_val(Funct3, operand_a, operand_b);
            end else if (state == BUSY && !flush) begin
                hi    <= nx_hi;
                lo    <= nx_lo;
                count <= count + CNT_W'(1);
                if (state_nx == DONE)
                    result <= fin;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed vectors with a result scoreboard for alu_ctrl_seq (XLEN=32).
module tb_alu_ctrl_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  ALUOp = '0;
    logic [6:0]  Funct7 = '0;
    logic [2:0]  Funct3 = '0;
    logic        op_valid = 1'b0, flush = 1'b0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic [3:0]  Operation;
    logic        is_muldiv, stall, busy, result_valid;
    logic [31:0] result;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = 33;
`endif

    typedef struct {
        logic [31:0] val;
        int          at;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] prev;

    alu_ctrl_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .op_valid(op_valid), .flush(flush), .operand_a(operand_a), .operand_b(operand_b),
        .Operation(Operation), .is_muldiv(is_muldiv), .stall(stall), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid) begin
            if (sbq.size() == 0)
                chk("unexpected result_valid", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                chk({e.name, " result"}, result, e.val);
                chk({e.name, " latency"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic mop(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat);
        int n = 0;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
        operand_a = a; operand_b = b; op_valid = 1'b1;
        sbq.push_back('{expv, cyc + lat, name});
        prev = expv;
        #1;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({name, " stall cycles"}, 32'(n), 32'(lat));
        op_valid = 1'b0; ALUOp = '0; Funct7 = '0;
        @(posedge clk); #1;
    endtask

    task automatic dec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3, input logic [3:0] expv);
        ALUOp = op; Funct7 = f7; Funct3 = f3; op_valid = 1'b1;
        #1;
        chk($sformatf("decode %b/%b/%b", op, f7, f3), 32'(Operation), 32'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset result_valid", 32'(result_valid), 0);
        chk("reset result", result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        dec(2'b10, 7'b0100000, 3'b000, 4'b0110);
        chk("sub is_muldiv", 32'(is_muldiv), 0);
        chk("sub stall", 32'(stall), 0);
        dec(2'b10, 7'b0000000, 3'b100, 4'b1100);
        dec(2'b00, 7'b0100000, 3'b000, 4'b0010);
        dec(2'b10, 7'b0000000, 3'b110, 4'b0001);
        dec(2'b10, 7'b0000000, 3'b111, 4'b0000);
        dec(2'b01, 7'b0000000, 3'b010, 4'b0111);
        dec(2'b10, 7'b0000000, 3'b001, 4'b0010);
        op_valid = 1'b0;
        @(posedge clk); #1;
        dec(2'b10, 7'b0000001, 3'b000, 4'b1111);
        chk("mul is_muldiv", 32'(is_muldiv), 1);
        op_valid = 1'b0; #1;
        chk("bubble is_muldiv", 32'(is_muldiv), 0);
        ALUOp = '0; Funct7 = '0;
        @(posedge clk); #1;

        mop("MUL",    3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        mop("MULHU",  3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
        mop("MULH",   3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        mop("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        mop("DIV",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        mop("REM",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        mop("DIV neg divisor", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        mop("REM neg divisor", 3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
        mop("DIVU",   3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33);
        mop("REMU",   3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33);
        mop("DIVU by zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, SLAT);
        mop("REMU by zero", 3'b111, 32'd5, 32'd0, 32'd5, SLAT);
        mop("REM by zero",  3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SLAT);
        mop("DIV overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SLAT);
        mop("REM overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, SLAT);
        mop("MUL zero",     3'b000, 32'd0, 32'd5, 32'd0, SLAT);

        // Flushed DIV must never report a result.
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
        operand_a = 32'd100; operand_b = 32'd7; op_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; op_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 32'(busy), 0);
        chk("flush result held", result, prev);
        repeat (40) @(posedge clk);
        #1;
        chk("flush stays idle", 32'(busy), 0);
        mop("MUL after flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // Mid-cycle asynchronous reset during a MUL.
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
        operand_a = 32'd9; operand_b = 32'd9; op_valid = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 0);
        chk("async reset result_valid", 32'(result_valid), 0);
        chk("async reset result", result, 0);
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset busy", 32'(busy), 0);
        mop("MULHU after reset", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor to the single-cycle ALU operation decoder.
- Decodes ALUOp/Funct7/Funct3 into the 4-bit ALU Operation code for base integer ops, with the same encodings as the existing core.
- Adds RV32M/RV64M support: decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and runs an internal radix-2 iterative multiply/divide engine.
- Raises a stall to freeze the PC/pipeline while the engine is busy; sits between the control unit and the ALU/writeback mux.

Parameters:
- XLEN, 32, operand/result width (32 or 64)
- CNT_W, $clog2(XLEN), iteration counter width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ALUOp  in  2  main-control ALU op class (00 load/store/addi-class, 01 branch, 10 R-type)
- Funct7  in  7  instruction funct7
- Funct3  in  3  instruction funct3
- op_valid  in  1  current instruction is valid (not a bubble)
- flush  in  1  abort any in-flight mul/div
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- Operation  out  4  ALU control code (combinational)
- is_muldiv  out  1  current instruction is an M-extension op (combinational)
- stall  out  1  hold PC and instruction (combinational)
- busy  out  1  engine iterating (registered)
- result_valid  out  1  one-cycle pulse: result holds final mul/div value
- result  out  XLEN  mul/div result (registered)

Behaviour:
- Base decode (combinational):
  - 0010 ADD: Funct3=000, except R-type SUB.
  - 0110 SUB: ALUOp=10, Funct7=0100000, Funct3=000.
  - 0111 SLT: Funct3=010.
  - 1100 XOR: Funct3=100.
  - 0001 OR: Funct3=110.
  - 0000 AND: Funct3=111.
  - 0010 for all other codes.
- M decode: is_muldiv = op_valid & ALUOp==10 & Funct7==0000001; Operation forced to 1111 (ALU output unused).
- States: IDLE, BUSY, DONE.
- IDLE:
  - If is_muldiv & !flush: latch operands and Funct3, compute operand magnitudes/sign fixups, set count=0, go to BUSY.
- BUSY:
  - One shift-add (mul) or restoring-subtract (div) step per cycle; count++.
  - When count==XLEN-1, go to DONE.
  - op_valid and operand changes are ignored (latched copies are used).
- DONE:
  - result_valid=1 for this cycle only; result updated at entry; go to IDLE.
- Latency: start cycle T, result_valid at T+XLEN+1.
- stall = is_muldiv & (state!=DONE). It is high in the IDLE start cycle and throughout BUSY, low in DONE so the core retires the instruction.
- A back-to-back M op is accepted in the following IDLE cycle. No request is accepted in DONE.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits with signed/signed, signed/unsigned, unsigned/unsigned semantics.
  - DIV/REM: truncate toward zero; remainder takes the dividend's sign.
- Special cases (required in both build variants):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): DIV = dividend; REM = 0.
- flush: any state goes to IDLE next edge; no result_valid; result unchanged; busy=0.
- Reset (async, any state): state IDLE, count 0, busy 0, result_valid 0, result 0. Combinational outputs follow inputs.
- result holds its last value until the next DONE.

Optional Feature:
- MULDIV_FAST_SPECIAL_EN defined:
  - Divide-by-zero, signed overflow, and multiply with either operand zero skip BUSY: IDLE goes directly to DONE.
  - Latency 1 (result_valid at T+1). stall is high only in the start cycle.
- Undefined: all M ops have fixed latency XLEN+1; special-case results are still correct.

Test Plan (XLEN=32):
- Base decode: ALUOp=10, Funct7=0100000, Funct3=000 -> Operation=0110, is_muldiv=0, stall=0. Funct3=100 with Funct7=0 -> 1100.
- MUL: a=0xFFFFFFFF, b=2 -> stall high for cycles T..T+32; result_valid at T+33 with result=0xFFFFFFFE. MULHU on the same operands -> 0x00000001.
- DIV/REM: a=-7, b=2 -> DIV=0xFFFFFFFD (-3); REM=0xFFFFFFFF (-1).
- Special cases: DIVU a=5, b=0 -> 0xFFFFFFFF. DIV a=0x80000000, b=-1 -> 0x80000000. REM same operands -> 0.
  - Latency T+33 without the macro, T+1 with it.
- flush at T+10 of a DIV -> IDLE at T+11; no result_valid; result keeps its prior value; the next MUL starts normally.
- rst_n asserted low at T+5 of a MUL, asynchronously (mid-cycle) -> busy, result_valid, result go to 0 immediately; IDLE on release.
